halt_pipe_ctrl: RTL

- Parametrised halt/sideband-flag tracker that runs alongside the ID/EX to MEM/WB pipeline registers.
- Carries valid, halt and FLAG_W sideband bits through STAGES register stages.
- Honours global stall and partial flush.
- Runs a RUN/DRAIN/HALTED state machine that stops fetch once a halt is accepted and reports a halt only when it reaches writeback.

---
 rtl/halt_pipe_ctrl_pkg.sv | 21 ++
 rtl/halt_pipe_stage.sv | 29 ++
 rtl/halt_pipe_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/halt_pipe_ctrl_pkg.sv
// Shared types for the halt/sideband tracker: FSM state encoding and the
// default stage-entry layout that halt_pipe_stage registers.
package halt_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam int FLAG_W_DEF = 2;

  typedef struct packed {
    logic                  valid;
    logic                  halt;
    logic [FLAG_W_DEF-1:0] flags;
  } stage_t;

  localparam stage_t BUBBLE = '0;

endpackage

// File: rtl/halt_pipe_stage.sv
// One pipeline slot of the halt tracker: flush loads a bubble, stall holds,
// otherwise the slot captures its predecessor. Entry layout is a type parameter.
module halt_pipe_stage
  import halt_pipe_ctrl_pkg::*;
#(
  parameter type entry_t = stage_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  entry_t d,
  input  logic   hold,
  input  logic   kill,
  output entry_t q
);

  // Stage register: kill beats hold so a flush still clears a stalled slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (kill) begin
      q <= '0;
    end else if (hold) begin
      q <= q;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/halt_pipe_ctrl.sv
// Halt/sideband-flag tracker running beside the ID/EX..MEM/WB registers with a
// RUN/DRAIN/HALTED controller. Optional macro HALT_RESUME_EN adds a resume input.
module halt_pipe_ctrl
  import halt_pipe_ctrl_pkg::*;
#(
  parameter int STAGES      = 3,
  parameter int FLAG_W      = 2,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              hlt_found,
  input  logic [FLAG_W-1:0] flag_in,
  input  logic              stall,
  input  logic              flush,
`ifdef HALT_RESUME_EN
  input  logic              resume,
`endif
  output logic              hlt,
  output logic              last_instr_was_halt,
  output logic              halt_pending,
  output logic [FLAG_W-1:0] flags_out,
  output logic              fetch_stop,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  drain_cycles
);

  typedef struct packed {
    logic              valid;
    logic              halt;
    logic [FLAG_W-1:0] flags;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_r;
  state_t            state_nxt;
  logic [CNT_W-1:0]  drain_r;
  logic              resume_hit;
  entry_t            head_s;
  entry_t            stg_d [STAGES];
  entry_t            stg_q [STAGES];
  logic [STAGES-1:0] stg_hold;
  logic [STAGES-1:0] stg_kill;
  logic [STAGES-1:0] cur_vh;
  logic [STAGES-1:0] nxt_vh;

`ifdef HALT_RESUME_EN
  assign resume_hit = resume && (state_r == ST_HALTED);
`else
  assign resume_hit = 1'b0;
`endif

  // Decode only feeds the pipe while running; otherwise bubbles drain through.
  always_comb begin
    head_s = '0;
    if (state_r == ST_RUN) begin
      head_s.valid = valid_in;
      head_s.halt  = hlt_found & valid_in;
      head_s.flags = flag_in;
    end else begin
      head_s = '0;
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign stg_d[i] = head_s;
    end else begin : g_body
      // A flushed instruction is squashed, so it must not leak into stage i.
      assign stg_d[i] = (flush && (i <= FLUSH_DEPTH)) ? '0 : stg_q[i-1];
    end

    assign stg_kill[i] = (flush && (i < FLUSH_DEPTH)) || ((i == STAGES - 1) && resume_hit);
    assign stg_hold[i] = stall || ((i == STAGES - 1) && stg_q[i].valid && stg_q[i].halt);
    assign cur_vh[i]   = stg_q[i].valid & stg_q[i].halt;
    assign nxt_vh[i]   = stg_kill[i] ? 1'b0 :
                         stg_hold[i] ? cur_vh[i] : (stg_d[i].valid & stg_d[i].halt);

    halt_pipe_stage #(.entry_t(entry_t)) u_stage (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (stg_d[i]),
      .hold (stg_hold[i]),
      .kill (stg_kill[i]),
      .q    (stg_q[i])
    );
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt;
    end
  end

  // FSM next state, judged on where the in-flight halt will sit after this edge.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_RUN: begin
        if (valid_in && hlt_found && !stall && !flush) state_nxt = ST_DRAIN;
        else                                           state_nxt = ST_RUN;
      end
      ST_DRAIN: begin
        if (nxt_vh[STAGES-1])       state_nxt = ST_HALTED;
        else if (nxt_vh == '0)      state_nxt = ST_RUN;
        else                        state_nxt = ST_DRAIN;
      end
      ST_HALTED: begin
        if (resume_hit) state_nxt = ST_RUN;
        else            state_nxt = ST_HALTED;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // FSM outputs.
  always_comb begin
    fetch_stop = 1'b0;
    if (state_r != ST_RUN) fetch_stop = 1'b1;
    else                   fetch_stop = 1'b0;
  end

  // Drain-cycle counter: restarts on entering DRAIN, saturates rather than wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_r <= '0;
    end else if ((state_r == ST_RUN) && (state_nxt == ST_DRAIN)) begin
      drain_r <= '0;
    end else if (state_r == ST_DRAIN) begin
      if (drain_r != CNT_MAX) drain_r <= drain_r + CNT_ONE;
      else                    drain_r <= drain_r;
    end else if (resume_hit) begin
      drain_r <= '0;
    end else begin
      drain_r <= drain_r;
    end
  end

  assign hlt                 = cur_vh[STAGES-1];
  assign last_instr_was_halt = cur_vh[0];
  assign halt_pending        = |cur_vh;
  assign flags_out           = stg_q[STAGES-1].valid ? stg_q[STAGES-1].flags : '0;
  assign state               = state_r;
  assign drain_cycles        = drain_r;

endmodule
